// File: rtl/mainreg_seq_pkg.sv
// Shared definitions for the main register file sequencer: opcodes, register
// indices, FSM states and write-data bus select codes.
package mainreg_seq_pkg;

    localparam int MR_DW = 8;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_MOV = 3'b001,
        OP_LDI = 3'b010,
        OP_SWP = 3'b011,
        OP_CLR = 3'b100,
        OP_SET = 3'b101,
        OP_RD  = 3'b110,
        OP_RSV = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        REG_A  = 2'd0,
        REG_B  = 2'd1,
        REG_C  = 2'd2,
        REG_IX = 2'd3
    } reg_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_SWP1 = 2'd2,
        ST_SWP2 = 2'd3
    } state_t;

    // Input order of the write-data bus mux
    typedef enum logic [1:0] {
        WSEL_OUTA = 2'd0,
        WSEL_IMM  = 2'd1,
        WSEL_OUTC = 2'd2,
        WSEL_TEMP = 2'd3
    } wsel_t;

    // Single-cycle commands that commit a regfile write in EXEC
    function automatic logic op_writes(input op_t op);
        return (op == OP_MOV) || (op == OP_LDI) || (op == OP_CLR) || (op == OP_SET);
    endfunction

endpackage

// File: rtl/mainreg_seq_busmux.sv
// 4-to-1 write-data bus multiplexer feeding the regfile IN bus.
module mainreg_seq_busmux
    import mainreg_seq_pkg::*;
#(
    parameter int DW = MR_DW
) (
    input  logic [1:0]    sel,
    input  logic [DW-1:0] in0,
    input  logic [DW-1:0] in1,
    input  logic [DW-1:0] in2,
    input  logic [DW-1:0] in3,
    output logic [DW-1:0] y
);

    always_comb begin
        y = in0;
        case (sel)
            2'd0:    y = in0;
            2'd1:    y = in1;
            2'd2:    y = in2;
            2'd3:    y = in3;
            default: y = in0;
        endcase
    end

endmodule

// File: rtl/mainreg_seq.sv
// Register-transfer sequencer in front of the 4-entry main register file;
// one command per handshake, SWP done in two write cycles through TEMP.
//
//   state | meaning
//   IDLE  | waiting for req, ready high
//   EXEC  | single-cycle command executes, done pulses
//   SWP1  | dst <= src value, TEMP <= old dst value
//   SWP2  | src <= TEMP, done pulses
module mainreg_seq
    import mainreg_seq_pkg::*;
#(
    parameter int DW = MR_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [2:0]    op,
    input  logic [1:0]    dst,
    input  logic [1:0]    src,
    input  logic [DW-1:0] imm,
    output logic          ready,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic          mrwe,
    output logic          wa1,
    output logic          wa0,
    output logic          ra1,
    output logic          ra0,
    output logic          ra3,
    output logic          ra2,
    output logic          ra4,
    output logic [DW-1:0] wdata,
    input  logic [DW-1:0] outa,
    input  logic [DW-1:0] outb,
    input  logic [DW-1:0] outc
);

    state_t        state;
    op_t           op_q;
    logic [1:0]    dst_q;
    logic [1:0]    src_q;
    logic [DW-1:0] imm_q;
    logic [DW-1:0] temp_q;
    logic [DW-1:0] rdata_q;

    logic [1:0]    wa;
    logic [1:0]    ra_a;
    logic [1:0]    ra_b;
    wsel_t         wsel;
    logic          bus_en;
    logic [DW-1:0] mux_y;

    assign ready = (state == ST_IDLE) & ~reset;
    assign rdata = rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            op_q    <= OP_NOP;
            dst_q   <= '0;
            src_q   <= '0;
            imm_q   <= '0;
            temp_q  <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        op_q  <= op_t'(op);
                        dst_q <= dst;
                        src_q <= src;
                        imm_q <= imm;
                        state <= (op_t'(op) == OP_SWP) ? ST_SWP1 : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (op_q == OP_RD) begin
                        rdata_q <= outa;
                    end
                    state <= ST_IDLE;
                end
                ST_SWP1: begin
                    temp_q <= outb;
                    state  <= ST_SWP2;
                end
                ST_SWP2: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Every regfile control is decoded from registered state only, so req
    // never reaches mrwe combinationally.
    always_comb begin
        mrwe   = 1'b0;
        done   = 1'b0;
        wa     = 2'd0;
        ra_a   = 2'd0;
        ra_b   = 2'd0;
        ra4    = 1'b0;
        wsel   = WSEL_OUTA;
        bus_en = 1'b0;
        case (state)
            ST_EXEC: begin
                done = 1'b1;
                wa   = dst_q;
                case (op_q)
                    OP_MOV: begin
                        ra_a = src_q;
                        wsel = WSEL_OUTA;
                    end
                    OP_LDI: wsel = WSEL_IMM;
                    OP_CLR: wsel = WSEL_OUTC;
                    OP_SET: begin
                        ra4  = 1'b1;
                        wsel = WSEL_OUTC;
                    end
                    OP_RD:  ra_a = src_q;
                    default: ;
                endcase
                bus_en = op_writes(op_q);
                mrwe   = op_writes(op_q);
            end
            ST_SWP1: begin
                ra_a   = src_q;
                ra_b   = dst_q;
                wa     = dst_q;
                wsel   = WSEL_OUTA;
                bus_en = 1'b1;
                mrwe   = 1'b1;
            end
            ST_SWP2: begin
                wa     = src_q;
                wsel   = WSEL_TEMP;
                bus_en = 1'b1;
                mrwe   = 1'b1;
                done   = 1'b1;
            end
            default: ;
        endcase
    end

    mainreg_seq_busmux #(.DW(DW)) u_busmux (
        .sel (wsel),
        .in0 (outa),
        .in1 (imm_q),
        .in2 (outc),
        .in3 (temp_q),
        .y   (mux_y)
    );

    assign wdata = bus_en ? mux_y : '0;
    assign wa1   = wa[1];
    assign wa0   = wa[0];
    assign ra1   = ra_a[1];
    assign ra0   = ra_a[0];
    assign ra3   = ra_b[1];
    assign ra2   = ra_b[0];

endmodule

// File: tb/tb_mainreg_seq.sv
// Bench for mainreg_seq with a behavioural 4-entry register file attached;
// a command table plus stream and reset-abort sequences, scored on done.
module tb_mainreg_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic [2:0] op = 3'b000;
    logic [1:0] dst = 2'd0;
    logic [1:0] src = 2'd0;
    logic [7:0] imm = 8'h00;
    logic       ready, done, mrwe;
    logic       wa1, wa0, ra1, ra0, ra3, ra2, ra4;
    logic [7:0] rdata, wdata, outa, outb, outc;

    logic [7:0] rf [4];
    int cyc = 0;
    int writes = 0;
    int exp_writes = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [2:0] op;
        logic [1:0] dst;
        logic [1:0] src;
        logic [7:0] imm;
        logic [1:0] ridx;
        logic [7:0] rval;
        logic [7:0] rdv;
        int         lat;
    } vec_t;

    typedef struct {
        vec_t v;
        int   acc;
    } exp_t;

    exp_t q[$];
    vec_t tbl[15];
    vec_t sv;
    int   accs[4];
    int   acc_dummy;

    mainreg_seq #(.DW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .op    (op),
        .dst   (dst),
        .src   (src),
        .imm   (imm),
        .ready (ready),
        .done  (done),
        .rdata (rdata),
        .mrwe  (mrwe),
        .wa1   (wa1),
        .wa0   (wa0),
        .ra1   (ra1),
        .ra0   (ra0),
        .ra3   (ra3),
        .ra2   (ra2),
        .ra4   (ra4),
        .wdata (wdata),
        .outa  (outa),
        .outb  (outb),
        .outc  (outc)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 4; i++) rf[i] = 8'h00;
    end

    assign outa = rf[{ra1, ra0}];
    assign outb = rf[{ra3, ra2}];
    assign outc = ra4 ? 8'hFF : 8'h00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mrwe) begin
            rf[{wa1, wa0}] <= wdata;
            writes <= writes + 1;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req_v);
        end
    endtask

    // write enable must never be seen while the sequencer is idle
    always @(negedge clk) begin
        if (!reset && ready) check("mrwe_in_idle", {31'd0, mrwe}, 32'd0);
    end

    // scoreboard: pop on each done, check latency, target register and rdata
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("latency", cyc - e.acc + 1, e.v.lat);
                    @(posedge clk);
                    #1;
                    check("reg_value", {24'd0, rf[e.v.ridx]}, {24'd0, e.v.rval});
                    check("rdata", {24'd0, rdata}, {24'd0, e.v.rdv});
                end
            end
        end
    end

    task automatic issue(input vec_t v, input bit keep, output int acc);
        exp_t e;
        int n;
        @(negedge clk);
        op  = v.op;
        dst = v.dst;
        src = v.src;
        imm = v.imm;
        req = 1'b1;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        acc = cyc;
        if (!keep) req = 1'b0;
        e.v = v;
        e.acc = acc;
        q.push_back(e);
        if (v.op == 3'b011) exp_writes += 2;
        else if (v.op == 3'b001 || v.op == 3'b010 || v.op == 3'b100 || v.op == 3'b101) exp_writes += 1;
    endtask

    initial begin
        //           op      dst    src    imm    ridx   rval   rdata  lat
        tbl[0]  = '{3'b010, 2'd1, 2'd0, 8'h5A, 2'd1, 8'h5A, 8'h00, 1};
        tbl[1]  = '{3'b110, 2'd0, 2'd1, 8'h00, 2'd1, 8'h5A, 8'h5A, 1};
        tbl[2]  = '{3'b010, 2'd0, 2'd0, 8'h11, 2'd0, 8'h11, 8'h5A, 1};
        tbl[3]  = '{3'b010, 2'd1, 2'd0, 8'h22, 2'd1, 8'h22, 8'h5A, 1};
        tbl[4]  = '{3'b011, 2'd1, 2'd0, 8'h00, 2'd0, 8'h22, 8'h5A, 2};
        tbl[5]  = '{3'b110, 2'd0, 2'd1, 8'h00, 2'd1, 8'h11, 8'h11, 1};
        tbl[6]  = '{3'b010, 2'd2, 2'd0, 8'h33, 2'd2, 8'h33, 8'h11, 1};
        tbl[7]  = '{3'b101, 2'd3, 2'd0, 8'h00, 2'd3, 8'hFF, 8'h11, 1};
        tbl[8]  = '{3'b100, 2'd2, 2'd0, 8'h00, 2'd2, 8'h00, 8'h11, 1};
        tbl[9]  = '{3'b001, 2'd0, 2'd3, 8'h00, 2'd0, 8'hFF, 8'h11, 1};
        tbl[10] = '{3'b000, 2'd0, 2'd1, 8'hAA, 2'd0, 8'hFF, 8'h11, 1};
        tbl[11] = '{3'b111, 2'd1, 2'd0, 8'h44, 2'd1, 8'h11, 8'h11, 1};
        tbl[12] = '{3'b011, 2'd3, 2'd3, 8'h00, 2'd3, 8'hFF, 8'h11, 2};
        tbl[13] = '{3'b001, 2'd0, 2'd0, 8'h00, 2'd0, 8'hFF, 8'h11, 1};
        tbl[14] = '{3'b110, 2'd0, 2'd3, 8'h00, 2'd3, 8'hFF, 8'hFF, 1};

        #1;
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_mrwe", {31'd0, mrwe}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rdata", {24'd0, rdata}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, ready}, 32'd1);

        for (int i = 0; i < 15; i++) issue(tbl[i], 1'b0, acc_dummy);

        // req held high: one LDI accepted every second cycle
        for (int i = 0; i < 4; i++) begin
            sv = '{3'b010, 2'(i), 2'd0, 8'hA0 + 8'(i * 17), 2'(i), 8'hA0 + 8'(i * 17), 8'hFF, 1};
            issue(sv, 1'b1, accs[i]);
        end
        req = 1'b0;
        for (int i = 1; i < 4; i++) check("stream_spacing", accs[i] - accs[i-1], 2);

        for (int n = 0; n < 20 && q.size() != 0; n++) @(negedge clk);
        check("queue_drained", q.size(), 0);
        @(negedge clk);
        check("write_count", writes, exp_writes);

        // reset during SWP1 aborts the swap before any write commits
        @(negedge clk);
        op  = 3'b011;
        src = 2'd0;
        dst = 2'd1;
        req = 1'b1;
        @(posedge clk);
        #3;
        req = 1'b0;
        reset = 1'b1;
        #1;
        check("abort_mrwe", {31'd0, mrwe}, 32'd0);
        check("abort_ready", {31'd0, ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready_after", {31'd0, ready}, 32'd1);
        check("abort_rdata", {24'd0, rdata}, 32'd0);
        check("abort_temp", {24'd0, dut.temp_q}, 32'd0);
        check("abort_a", {24'd0, rf[0]}, 32'h0A0);
        check("abort_b", {24'd0, rf[1]}, 32'h0B1);
        check("abort_writes", writes, exp_writes);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1);
    end

endmodule
